// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if
// Bundles the read-side FIFO signals between the read controller and its
// surroundings (synchronizer, FIFO memory and consumer).
//   rq2_wptr  : Gray write pointer already synchronized into the read domain
//   mem_rdata : combinational read data from the FIFO memory at raddr
//   rd_ready  : consumer accepts rd_data this cycle
//   raddr     : memory read address
//   rptr      : registered Gray read pointer, toward the write domain
//   rempty    : registered empty flag for the memory side
//   rd_data   : registered output word
//   rd_valid  : rd_data holds an unconsumed word
//   rlevel    : registered count of words in memory not yet popped
// The slave modport is the controller; the master modport is everything
// around it.
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 7
);
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  logic [PTR_WIDTH-1:0]  rq2_wptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [PTR_WIDTH-1:0]  rptr;
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [PTR_WIDTH-1:0]  rlevel;

  modport master (
    output rq2_wptr,
    output mem_rdata,
    output rd_ready,
    input  raddr,
    input  rptr,
    input  rempty,
    input  rd_data,
    input  rd_valid,
    input  rlevel
  );

  modport slave (
    input  rq2_wptr,
    input  mem_rdata,
    input  rd_ready,
    output raddr,
    output rptr,
    output rempty,
    output rd_data,
    output rd_valid,
    output rlevel
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
// Read-side controller of the dual-clock FIFO, entirely in the read clock
// domain. Owns the binary and Gray read pointers, addresses the FIFO memory,
// derives the registered empty flag from the synchronized write pointer,
// reports occupancy and hands popped words to the consumer through a
// registered valid/ready output stage.
// Ports:
//   clk : read-domain clock, all state on the rising edge
//   rst : asynchronous active-low reset (0 = reset)
//   bus : fifo_rd_ctrl_if slave modport (pointer, memory and consumer signals)
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH  = 4,
  parameter int FIFO_LENGTH = 128,
  parameter int ADDR_WIDTH  = 7
) (
  input logic           clk,
  input logic           rst,
  fifo_rd_ctrl_if.slave bus
);
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  // The pointer arithmetic relies on the memory depth being exactly
  // 2**ADDR_WIDTH so that the extra MSB distinguishes full from empty.
  generate
    if (FIFO_LENGTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("fifo_rd_ctrl: FIFO_LENGTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  logic [PTR_WIDTH-1:0]  rbin;
  logic [PTR_WIDTH-1:0]  rbin_next;
  logic [PTR_WIDTH-1:0]  rgray;
  logic [PTR_WIDTH-1:0]  rgray_next;
  logic [PTR_WIDTH-1:0]  wbin;
  logic [PTR_WIDTH-1:0]  rlevel_q;
  logic [PTR_WIDTH-1:0]  rlevel_next;
  logic                  rempty_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  pop;

  // A word is popped from memory whenever memory is non-empty and the output
  // register is free or being drained this cycle, which allows one word per
  // clock under continuous acceptance. The write pointer is converted from
  // Gray to binary (bit i is the XOR of all Gray bits at or above i) so the
  // occupancy can be formed by plain subtraction against the next read
  // pointer; the word parked in the output register is therefore excluded.
  always_comb begin
    pop         = ~rempty_q & (~rd_valid_q | bus.rd_ready);
    rbin_next   = rbin + {{(PTR_WIDTH-1){1'b0}}, pop};
    rgray_next  = (rbin_next >> 1) ^ rbin_next;
    wbin        = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      wbin[i] = ^(bus.rq2_wptr >> i);
    end
    rlevel_next = wbin - rbin_next;
  end

  // Pointer, empty and occupancy registers. Empty is an exact full-width Gray
  // equality, so a completely full memory (pointers differing in the MSBs)
  // never looks empty, and the pop that consumes the last word raises empty
  // on the same edge so no extra pop can follow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbin     <= '0;
      rgray    <= '0;
      rempty_q <= 1'b1;
      rlevel_q <= '0;
    end else begin
      rbin     <= rbin_next;
      rgray    <= rgray_next;
      rempty_q <= (rgray_next == bus.rq2_wptr);
      rlevel_q <= rlevel_next;
    end
  end

  // Output stage: a pop loads the word currently addressed in memory and
  // keeps valid high even if the previous word is being accepted in the
  // same cycle; without a pop an accepted word simply drops valid while the
  // data register holds its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (pop) begin
      rd_data_q  <= bus.mem_rdata;
      rd_valid_q <= 1'b1;
    end else if (bus.rd_ready) begin
      rd_valid_q <= 1'b0;
    end
  end

  assign bus.raddr    = rbin[ADDR_WIDTH-1:0];
  assign bus.rptr     = rgray;
  assign bus.rempty   = rempty_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rlevel   = rlevel_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl
// Self-checking bench for fifo_rd_ctrl. Words written into the modelled FIFO
// memory are pushed into an expected-data queue; a monitor pops and compares
// on every rd_valid/rd_ready handshake and also tracks occupancy, output
// valid and pointer stability against a small count-based model.
module tb_fifo_rd_ctrl;
  localparam int DATA_WIDTH  = 4;
  localparam int FIFO_LENGTH = 128;
  localparam int ADDR_WIDTH  = 7;
  localparam int PTR_WIDTH   = ADDR_WIDTH + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  fifo_rd_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_LENGTH(FIFO_LENGTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DATA_WIDTH-1:0] mem [0:FIFO_LENGTH-1];
  assign bus.mem_rdata = mem[bus.raddr];

  int checks   = 0;
  int errors   = 0;
  int wcnt     = 0;
  int consumed = 0;
  logic [DATA_WIDTH-1:0] expQ [$];

  // Count-based reference: visible words minus words moved into the output
  // register gives availability; the output register follows valid/ready.
  logic [PTR_WIDTH-1:0] mVisible;
  logic [PTR_WIDTH-1:0] mBin;
  logic [PTR_WIDTH-1:0] mLevel;
  logic                 mValid;
  logic                 mPop;

  assign mPop = ((mVisible - mBin) != 8'd0) && (!mValid || bus.rd_ready);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mVisible <= '0;
      mBin     <= '0;
      mLevel   <= '0;
      mValid   <= 1'b0;
    end else begin
      mBin     <= mBin + {7'd0, mPop};
      mVisible <= wcnt[7:0];
      mLevel   <= wcnt[7:0] - mBin - {7'd0, mPop};
      if (mPop) mValid <= 1'b1;
      else if (bus.rd_ready) mValid <= 1'b0;
    end
  end

  function automatic logic [7:0] gray(input int b);
    logic [7:0] v;
    v = b[7:0];
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] wptr, input logic ready);
    bus.rq2_wptr = wptr;
    bus.rd_ready = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [DATA_WIDTH-1:0] d);
    mem[wcnt % FIFO_LENGTH] = d;
    expQ.push_back(d);
    wcnt++;
    bus.rq2_wptr = gray(wcnt);
  endtask

  task automatic doReset();
    rst = 1'b0;
    wcnt = 0;
    consumed = 0;
    expQ.delete();
    applyStimulus(8'h00, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic drainAll(input string name);
    int n;
    n = 0;
    tick();
    while (!(bus.rempty && !bus.rd_valid) && n < 400) begin
      tick();
      n++;
    end
    checkOutput({name, "_drain_done"}, 32'(n < 400), 32'd1);
  endtask

  // Monitor: scoreboard compare on each handshake, model comparisons every
  // cycle, and a check that the read pointer never moves while empty.
  logic                 prevRempty = 1'b1;
  logic [PTR_WIDTH-1:0] prevRptr   = '0;

  initial begin
    logic [DATA_WIDTH-1:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("rlevel_model", 32'(bus.rlevel), 32'(mLevel));
        checkOutput("rd_valid_model", 32'(bus.rd_valid), 32'(mValid));
        if (prevRempty) checkOutput("no_pop_when_empty", 32'(bus.rptr), 32'(prevRptr));
        if (bus.rd_valid && bus.rd_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_underflow actual=0x%0h expected=none at %0t", bus.rd_data, $time);
          end else begin
            exp = expQ.pop_front();
            checkOutput("rd_data_sb", 32'(bus.rd_data), 32'(exp));
          end
          consumed++;
        end
      end
      prevRempty = bus.rempty;
      prevRptr   = bus.rptr;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int validCnt;
    int firstIdx;
    int lastIdx;
    int target;
    int cyc;

    // Reset held with random inputs and memory contents.
    for (int i = 0; i < FIFO_LENGTH; i++) mem[i] = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end
    checkOutput("reset_rptr", 32'(bus.rptr), 32'h00);
    checkOutput("reset_raddr", 32'(bus.raddr), 32'h00);
    checkOutput("reset_rempty", 32'(bus.rempty), 32'h1);
    checkOutput("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    checkOutput("reset_rd_data", 32'(bus.rd_data), 32'h0);
    checkOutput("reset_rlevel", 32'(bus.rlevel), 32'h0);
    doReset();

    // Single word under backpressure.
    $display("[TB] single word with backpressure");
    bus.rd_ready = 1'b0;
    writeWord(4'hA);
    tick();
    checkOutput("single_rempty_e1", 32'(bus.rempty), 32'h0);
    checkOutput("single_rd_valid_e1", 32'(bus.rd_valid), 32'h0);
    checkOutput("single_rlevel_e1", 32'(bus.rlevel), 32'h1);
    tick();
    checkOutput("single_rd_valid_e2", 32'(bus.rd_valid), 32'h1);
    checkOutput("single_rd_data_e2", 32'(bus.rd_data), 32'hA);
    checkOutput("single_rptr_e2", 32'(bus.rptr), 32'h01);
    checkOutput("single_raddr_e2", 32'(bus.raddr), 32'h01);
    checkOutput("single_rempty_e2", 32'(bus.rempty), 32'h1);
    checkOutput("single_rlevel_e2", 32'(bus.rlevel), 32'h0);
    repeat (5) tick();
    checkOutput("hold_rd_valid", 32'(bus.rd_valid), 32'h1);
    checkOutput("hold_rd_data", 32'(bus.rd_data), 32'hA);
    checkOutput("hold_rptr", 32'(bus.rptr), 32'h01);
    checkOutput("hold_rempty", 32'(bus.rempty), 32'h1);

    // Mid-stream reset takes effect without a clock edge.
    #2;
    rst = 1'b0;
    wcnt = 0;
    consumed = 0;
    expQ.delete();
    applyStimulus(8'h00, 1'b0);
    #1;
    checkOutput("async_rptr", 32'(bus.rptr), 32'h00);
    checkOutput("async_raddr", 32'(bus.raddr), 32'h00);
    checkOutput("async_rempty", 32'(bus.rempty), 32'h1);
    checkOutput("async_rd_valid", 32'(bus.rd_valid), 32'h0);
    checkOutput("async_rd_data", 32'(bus.rd_data), 32'h0);
    checkOutput("async_rlevel", 32'(bus.rlevel), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming five words at full throughput.
    $display("[TB] streaming five words");
    bus.rd_ready = 1'b1;
    for (int i = 1; i <= 5; i++) writeWord(4'(i));
    checkOutput("stream_wptr_gray", 32'(bus.rq2_wptr), 32'h07);
    validCnt = 0;
    firstIdx = -1;
    lastIdx  = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rd_valid) begin
        validCnt++;
        if (firstIdx < 0) firstIdx = i;
        lastIdx = i;
      end
    end
    checkOutput("stream_valid_cycles", 32'(validCnt), 32'd5);
    checkOutput("stream_valid_span", 32'(lastIdx - firstIdx), 32'd4);
    checkOutput("stream_end_rd_valid", 32'(bus.rd_valid), 32'h0);
    checkOutput("stream_end_rempty", 32'(bus.rempty), 32'h1);
    checkOutput("stream_end_rptr", 32'(bus.rptr), 32'h07);
    checkOutput("stream_end_raddr", 32'(bus.raddr), 32'h05);

    // Completely full memory, then drain.
    $display("[TB] full memory");
    doReset();
    bus.rd_ready = 1'b0;
    for (int i = 0; i < FIFO_LENGTH; i++) writeWord(4'((i * 3 + 1) & 15));
    checkOutput("full_wptr_gray", 32'(bus.rq2_wptr), 32'hC0);
    tick();
    checkOutput("full_rempty", 32'(bus.rempty), 32'h0);
    checkOutput("full_rlevel", 32'(bus.rlevel), 32'd128);
    checkOutput("full_rd_valid", 32'(bus.rd_valid), 32'h0);
    bus.rd_ready = 1'b1;
    drainAll("full");
    checkOutput("full_end_rptr", 32'(bus.rptr), 32'hC0);
    checkOutput("full_end_raddr", 32'(bus.raddr), 32'h00);
    checkOutput("full_end_rempty", 32'(bus.rempty), 32'h1);
    checkOutput("full_end_rlevel", 32'(bus.rlevel), 32'h0);

    // Wrap past the end of memory.
    $display("[TB] wrap-around");
    writeWord(4'h9);
    writeWord(4'hB);
    writeWord(4'hD);
    checkOutput("wrap_wptr_gray", 32'(bus.rq2_wptr), 32'hC2);
    drainAll("wrap");
    checkOutput("wrap_end_rptr", 32'(bus.rptr), 32'hC2);
    checkOutput("wrap_end_raddr", 32'(bus.raddr), 32'h03);
    checkOutput("wrap_end_rempty", 32'(bus.rempty), 32'h1);
    checkOutput("wrap_end_rlevel", 32'(bus.rlevel), 32'h0);

    // Random accept/stall mix over 1000 words.
    $display("[TB] random accept/stall mix");
    target = wcnt + 1000;
    cyc = 0;
    while (consumed < target && cyc < 20000) begin
      applyStimulus(gray(wcnt), 1'($urandom_range(0, 1)));
      if (wcnt < target && (wcnt - consumed) < 100 && $urandom_range(0, 3) != 0)
        writeWord(4'($urandom));
      tick();
      cyc++;
    end
    checkOutput("random_all_consumed", 32'(consumed >= target), 32'd1);
    bus.rd_ready = 1'b1;
    drainAll("random");
    checkOutput("random_sb_empty", 32'(expQ.size()), 32'd0);
    checkOutput("random_consumed_count", 32'(consumed), 32'(wcnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller of the dual-clock FIFO, living entirely in the read clock domain. It owns the read pointer (binary and Gray), drives the read address into the FIFO memory, and computes the registered empty flag from the write pointer already synchronized into this domain. It also reports occupancy and presents popped words to the consumer through a registered valid/ready output stage. It is the counterpart of the write-side pointer/full logic and pairs with the FIFO memory's combinational read port.

## Interface
- DATA_WIDTH, 4, width of one FIFO word
- FIFO_LENGTH, 128, memory depth; power of two
- ADDR_WIDTH, 7, log2(FIFO_LENGTH); pointer width PTR_WIDTH = ADDR_WIDTH+1 (matches `WPTR_WIDTH)

Ports:
- clk  in  1  read-domain clock; one clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- rq2_wptr  in  PTR_WIDTH  Gray write pointer, already 2-FF synchronized into clk domain
- mem_rdata  in  DATA_WIDTH  combinational read data from FIFO memory at raddr
- rd_ready  in  1  consumer accepts rd_data this cycle
- raddr  out  ADDR_WIDTH  memory read address = rbin[ADDR_WIDTH-1:0]
- rptr  out  PTR_WIDTH  registered Gray read pointer, to write-domain synchronizer
- rempty  out  1  registered empty flag (memory side)
- rd_data  out  DATA_WIDTH  registered output word
- rd_valid  out  1  rd_data holds an unconsumed word
- rlevel  out  PTR_WIDTH  registered count of words in memory not yet popped (0..FIFO_LENGTH)

## Operation
- State: rbin (PTR_WIDTH binary), rptr (Gray), rempty, rd_data, rd_valid, rlevel.
- Pop: pop = ~rempty & (~rd_valid | rd_ready). Pop is never performed while rempty=1.
- rbin_next = rbin + pop (mod 2^PTR_WIDTH); rgray_next = (rbin_next >> 1) ^ rbin_next.
- Each edge: rbin <= rbin_next; rptr <= rgray_next; rempty <= (rgray_next == rq2_wptr), a full-width compare including the MSB.
- Output stage: on pop, rd_data <= mem_rdata (word at current raddr), rd_valid <= 1. Else if rd_ready, rd_valid <= 0 and rd_data holds. Else hold.
- Occupancy: wbin = gray-to-binary(rq2_wptr); rlevel <= wbin - rbin_next (mod 2^PTR_WIDTH). The word held in the output register is excluded.
- Wrap-around: raddr wraps FIFO_LENGTH-1 -> 0; the pointer MSB toggles every FIFO_LENGTH pops. Empty is exact Gray equality, so a full memory (pointers differing only in the MSB region) never reads as empty.
- Simultaneous pop and consumer accept: the new word replaces the old one and rd_valid stays 1, giving full throughput of one word per clock.
- rd_ready while rd_valid=0 has no effect beyond enabling pop.
- Reset (asserted at any time, including mid-stream) forces immediately: rbin=0, rptr=0, rempty=1, rd_valid=0, rd_data=0, rlevel=0. Release is synchronous to the next clk edge. The write side is reset in the same event; no partial state survives.

## Timing
- Write visibility: rq2_wptr changes before edge N -> rempty falls at edge N -> pop at edge N+1 -> rd_valid=1 after edge N+1. Two read clocks from synchronized pointer to valid output.
- Last word: the pop edge that makes rgray_next equal rq2_wptr also sets rempty=1 in the same edge; no extra pop occurs.
- rptr changes by at most one Gray step per clock, with single-bit transitions only.
- rd_data/rd_valid are stable while rd_valid=1 and rd_ready=0.
- rlevel lags rq2_wptr by one clock.

## Test plan
- Reset: hold rst=0 and drive random inputs -> rptr=0x00, raddr=0, rempty=1, rd_valid=0, rd_data=0, rlevel=0. Assert rst mid-stream -> same values without waiting for a clock edge.
- Single word, backpressure: rq2_wptr=0x01, mem[0]=0xA, rd_ready=0 -> rempty=0 after edge 1. At edge 2: rd_valid=1, rd_data=0xA, rptr=0x01, raddr=1, rempty=1. Holding rd_ready=0 for 5 clocks -> all unchanged.
- Streaming: rq2_wptr=gray(5)=0x07, rd_ready=1, mem[0..4]=1..5 -> rd_valid high 5 consecutive cycles with rd_data 1,2,3,4,5; then rd_valid=0 and rempty=1.
- Full memory: rq2_wptr=gray(128)=0xC0, rbin=0 -> rempty=0, rlevel=128. Drain all 128 words -> rptr=0xC0, raddr=0, rempty=1, rlevel=0.
- Wrap-around: continue with rq2_wptr=gray(131)=0xC2 -> three pops read mem[0],mem[1],mem[2]; rptr ends at 0xC2; rempty=1.
- Mid-stream accept/stall mix: random rd_ready over 1000 words -> scoreboard shows in-order data with no loss or duplication, rlevel equals the model count every cycle, and no pop is ever made while rempty=1.
